itcm_arb_ctrl: RTL
==================

// Module: itcm_arb_ctrl
// PURPOSE
//  Controller for the single-port ITCM SRAM. Arbitrates between the IFU fetch port and the LSU
//  load/store port, drives SRAM cs/we/addr/wdata/wem and routes the 1-cycle-latency read data
//  back to the owning requester. Exports ifu_holdup so the fetch path can reuse the lane the
//  SRAM still holds instead of re-reading it. Sits between ifu_ifu2itcm and the ITCM RAM macro.
// PARAMETERS
//  RAM_AW  14  SRAM word-address width (depth = 2**RAM_AW words)
//  DW      32  SRAM data width in bits; write-mask width = DW/8
// PORTS
//  clk            in   1        core clock
//  rst            in   1        asynchronous active-high reset
//  ifu_cmd_valid  in   1        IFU read request valid
//  ifu_cmd_ready  out  1        IFU request accepted when valid & ready
//  ifu_cmd_addr   in   RAM_AW   IFU word address
//  ifu_rsp_valid  out  1        IFU read data valid
//  ifu_rsp_ready  in   1        IFU accepts response
//  ifu_rsp_rdata  out  DW       IFU read data (SRAM dout)
//  ifu_holdup     out  1        SRAM dout still holds the last IFU-read lane
//  lsu_cmd_valid  in   1        LSU request valid
//  lsu_cmd_ready  out  1        LSU request accepted
//  lsu_cmd_read   in   1        1 = read, 0 = write
//  lsu_cmd_addr   in   RAM_AW   LSU word address
//  lsu_cmd_wdata  in   DW       LSU write data
//  lsu_cmd_wmask  in   DW/8     LSU byte-write enables
//  lsu_rsp_valid  out  1        LSU response valid (reads and writes)
//  lsu_rsp_ready  in   1        LSU accepts response
//  lsu_rsp_rdata  out  DW       LSU read data (0 for writes)
//  ram_cs         out  1        SRAM chip select
//  ram_we         out  1        SRAM write enable
//  ram_addr       out  RAM_AW   SRAM address
//  ram_wdata      out  DW       SRAM write data
//  ram_wem        out  DW/8     SRAM byte-write mask
//  ram_dout       in   DW       SRAM read data, valid the cycle after cs & ~we, held until next cs
// BEHAVIOUR
//  - Reset: all *_ready, *_rsp_valid, ram_cs/we, ifu_holdup = 0; ram_addr/wdata/wem = 0; state IDLE; owner = IFU.
//  - ram_* are combinational from the granted command: ram_cs = grant, ram_we = ~lsu_cmd_read when LSU granted.
//  - At most one outstanding transaction. States: IDLE (none outstanding), PEND (rsp_valid up for owner).
//  - Grant allowed in IDLE, or in PEND in the same cycle the owner's rsp handshakes (back-to-back, 1 op/cycle).
//  - Arbitration default: fixed LSU priority. *_cmd_ready = grant to that port; the loser sees ready=0.
//  - Accepted cmd at cycle N -> owner rsp_valid at N+1; rsp_rdata = ram_dout (reads), 0 (LSU writes).
//  - rsp_valid holds with stable data until rsp_ready; SRAM is not re-selected while PEND, so dout holds.
//  - PEND->IDLE on rsp handshake with no new grant; PEND->PEND on handshake plus new grant.
//  - ifu_holdup = 1 after any IFU read is accepted; cleared by any later ram_cs (IFU or LSU, read or write).
//    Also cleared in the cycle an IFU cmd is granted, then set again on the next edge.
//  - Requests are never dropped: a valid that is not ready must be held by the requester (not checked here).
//  - Reset asserted mid-PEND: the response is discarded; outputs return to reset values asynchronously.
// CONFIGURATION
//  ITCM_ARB_RR_EN defined: round-robin arbitration. Priority toggles to the other port after each grant
//    made while both ports were valid. Reset priority = LSU.
//  ITCM_ARB_RR_EN undefined: fixed LSU priority, so IFU can starve while LSU is continuously valid.
// TESTING
//  1 IFU read addr 0x010, ram preloaded 0xDEADBEEF, rsp_ready=1 -> ram_cs at N, ifu_rsp_valid/rdata=0xDEADBEEF at N+1, ifu_holdup=1 afterwards.
//  2 IFU and LSU valid in the same cycle, fixed mode -> LSU granted first, IFU granted in the cycle LSU rsp handshakes.
//    With ITCM_ARB_RR_EN and both ports held valid -> grants alternate LSU, IFU, LSU, IFU.
//  3 LSU write 0x0AA wdata 0x12345678 wmask 4'b0011, then LSU read 0x0AA -> write rsp rdata=0;
//    read returns 0x????5678 with upper bytes unchanged.
//  4 IFU read with ifu_rsp_ready=0 for 3 cycles -> rsp_valid and rdata held stable, no ram_cs, lsu_cmd_ready=0 throughout.
//  5 IFU read followed by LSU read -> ifu_holdup falls on the LSU ram_cs cycle and stays 0.
//  6 rst pulsed while PEND -> rsp_valid=0 immediately; first post-reset IFU request is served normally.

Source files
------------

// File: rtl/itcm_arb_ctrl.sv
// rtl/itcm_arb_ctrl.sv - single-port ITCM SRAM arbiter between IFU fetch and LSU load/store
// Define ITCM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module itcm_arb_ctrl #(
  parameter int RAM_AW = 14,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_cmd_valid,
  output logic              ifu_cmd_ready,
  input  logic [RAM_AW-1:0] ifu_cmd_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DW-1:0]     ifu_rsp_rdata,
  output logic              ifu_holdup,
  input  logic              lsu_cmd_valid,
  output logic              lsu_cmd_ready,
  input  logic              lsu_cmd_read,
  input  logic [RAM_AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0]     lsu_cmd_wdata,
  input  logic [DW/8-1:0]   lsu_cmd_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DW-1:0]     lsu_rsp_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  output logic [DW/8-1:0]   ram_wem,
  input  logic [DW-1:0]     ram_dout
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state;
  logic   ifu_rsp_valid_q;
  logic   lsu_rsp_valid_q;
  logic   owner_wr;
  logic   holdup_q;
  logic   rsp_hs;
  logic   can_grant;
  logic   lsu_wins;
  logic   grant_lsu;
  logic   grant_ifu;

  // The rsp_valid registers double as the owner record: at most one is set.
  assign rsp_hs    = (ifu_rsp_valid_q & ifu_rsp_ready) | (lsu_rsp_valid_q & lsu_rsp_ready);
  assign can_grant = ~rst & ((state == IDLE) | rsp_hs);

`ifdef ITCM_ARB_RR_EN
  logic prio_lsu;

  // Priority flips only on contended grants, so a lone requester never shifts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_lsu <= 1'b1;
    end else if (ifu_cmd_valid & lsu_cmd_valid & can_grant) begin
      prio_lsu <= ~prio_lsu;
    end
  end

  assign lsu_wins = ~ifu_cmd_valid | prio_lsu;
`else
  assign lsu_wins = 1'b1;
`endif

  assign grant_lsu = can_grant & lsu_cmd_valid & lsu_wins;
  assign grant_ifu = can_grant & ifu_cmd_valid & ~grant_lsu;

  assign ifu_cmd_ready = grant_ifu;
  assign lsu_cmd_ready = grant_lsu;

  assign ram_cs    = grant_lsu | grant_ifu;
  assign ram_we    = grant_lsu & ~lsu_cmd_read;
  assign ram_addr  = grant_lsu ? lsu_cmd_addr : (grant_ifu ? ifu_cmd_addr : '0);
  assign ram_wdata = ram_we ? lsu_cmd_wdata : '0;
  assign ram_wem   = ram_we ? lsu_cmd_wmask : '0;

  // SRAM is never reselected while a response is pending, so dout stays stable.
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_rdata = ifu_rsp_valid_q ? ram_dout : '0;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_rdata = (lsu_rsp_valid_q & ~owner_wr) ? ram_dout : '0;

  assign ifu_holdup = holdup_q & ~ram_cs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      owner_wr        <= 1'b0;
      holdup_q        <= 1'b0;
    end else begin
      if (ram_cs) begin
        state           <= PEND;
        ifu_rsp_valid_q <= grant_ifu;
        lsu_rsp_valid_q <= grant_lsu;
        owner_wr        <= ram_we;
      end else if (rsp_hs) begin
        state           <= IDLE;
        ifu_rsp_valid_q <= 1'b0;
        lsu_rsp_valid_q <= 1'b0;
        owner_wr        <= 1'b0;
      end

      if (grant_ifu) begin
        holdup_q <= 1'b1;
      end else if (ram_cs) begin
        holdup_q <= 1'b0;
      end
    end
  end

endmodule
